vram_write_scheduler: RTL and testbench
=======================================

Name: vram_write_scheduler

Overview:
- Owns the single GPU VRAM write port and shares it between two requesters: CPU bus writes (single-word, valid/ready) and a hardware fill engine that writes a constant byte over an address range.
- Fill covers bulk init of PMF/PMB/NTBL/OBM regions.
- All writes are gated by a VRAM-writable window (vblank) from the GPU timing block.
- The CPU has strict priority; the fill engine uses every free writable cycle.

Parameters:
- ADDR_WIDTH, 12, VRAM address width (matches `VRAM_ADDR_WIDTH`).
- VRAM_SIZE, 2304 (12'h900), number of valid VRAM bytes; addresses >= VRAM_SIZE are never written.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  synchronous, active-high reset.
- vram_writable  input  1  VRAM may be written this cycle (vblank window).
- cpu_valid  input  1  CPU write request.
- cpu_addr  input  ADDR_WIDTH  CPU write address.
- cpu_data  input  8  CPU write data.
- cpu_ready  output  1  CPU request accepted this cycle when cpu_valid is also high.
- fill_start  input  1  one-cycle pulse that launches a fill.
- fill_base  input  ADDR_WIDTH  first fill address.
- fill_len  input  ADDR_WIDTH+1  number of bytes to fill (0..4096).
- fill_value  input  8  fill byte.
- fill_busy  output  1  fill in progress.
- fill_done  output  1  one-cycle pulse on fill completion.
- vram_addr  output  ADDR_WIDTH  registered write address.
- vram_data  output  8  registered write data.
- vram_we  output  1  registered write enable.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - vram_we=0, vram_addr=0, vram_data=0, fill_busy=0, fill_done=0.
  - Internal offset, base, length and value registers clear.
  - Reset mid-fill aborts the fill with no done pulse; rst overrides all inputs that cycle.
- cpu_ready = vram_writable & ~rst (combinational). This holds in all FSM states.
- CPU accept (cpu_valid & cpu_ready in cycle N):
  - vram_addr/vram_data take cpu_addr/cpu_data at the end of N.
  - vram_we=1 during N+1 (1-cycle latency).
  - If cpu_addr >= VRAM_SIZE the request is still accepted, but vram_we stays 0 (write dropped).
- FSM states IDLE, FILL.
  - IDLE -> FILL on fill_start when fill_len != 0. base/len/value are latched and the offset is cleared.
  - IDLE with fill_start and fill_len == 0: no writes; fill_done pulses in the next cycle; stays IDLE.
  - fill_start while in FILL is ignored; latched parameters are unchanged.
  - fill_busy = (state == FILL), registered. It is high starting the cycle after fill_start.
- Fill issue (cycle N, state FILL): issue when vram_writable=1 and no CPU accept in N.
  - On issue: vram_addr = base+offset (ADDR_WIDTH bits), vram_data = value, vram_we=1 in N+1, offset increments.
  - No issue: vram_we=0 in N+1 (unless a CPU write occupies it) and offset holds.
- Fill termination: the issue in which offset+1 == len, or the issue in which base+offset == VRAM_SIZE-1, is the last write.
  - FILL -> IDLE at the end of that cycle.
  - fill_done=1 and fill_busy=0 in N+1, coinciding with the last vram_we.
  - A fill never wraps past VRAM_SIZE-1; remaining bytes are discarded.
  - If fill_base >= VRAM_SIZE at start: zero writes, fill_done next cycle, stays IDLE.
- vram_writable dropping mid-fill pauses the fill without losing the offset; it resumes when writable returns.
- At most one write per cycle; a CPU write and a fill write never coincide.
- fill_done is high for exactly one cycle per launched fill.

Test Plan:
- Reset then idle, writable=1 -> vram_we=0, fill_busy=0, cpu_ready=1; rst high -> cpu_ready=0.
- fill_start with base=12'h400, len=4, value=8'hAA, writable=1 at T -> vram_we high T+2..T+5 with addr 400,401,402,403 and data AA; fill_done and busy=0 at T+5.
- Same fill, cpu_valid with addr=12'h010, data=8'h5C during T+3 -> CPU write appears at T+4; fill addresses 402,403 shift one cycle later; done at T+6.
- Fill base=12'h8FE, len=10 -> exactly two writes (8FE, 8FF) then fill_done; CPU write to 12'h900 -> accepted, vram_we=0.
- vram_writable low for 3 cycles mid-fill (base=0, len=6) -> no writes and cpu_ready=0 while low; all six addresses 0..5 written once, in order.
- fill_start with len=0 -> fill_done next cycle, no vram_we; rst asserted mid-fill -> busy=0 next cycle, no fill_done; fill_start during FILL -> ignored.

Source files
------------

// File: rtl/vram_write_scheduler.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler
//
// This block owns the single GPU VRAM write port and shares it between two
// sources:
//   * CPU bus writes: one byte per request, using a valid/ready handshake.
//     The CPU always has strict priority.
//   * A hardware fill engine: it writes one constant byte over an address
//     range and uses every writable cycle that the CPU leaves free.
// No write happens outside the vram_writable (vblank) window. The block never
// writes an address at or above VRAM_SIZE.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   vram_writable   VRAM may be written this cycle
//   cpu_valid       CPU write request
//   cpu_addr        CPU write address
//   cpu_data        CPU write data
//   cpu_ready       request accepted this cycle (combinational)
//   fill_start      one-cycle pulse that launches a fill
//   fill_base       first fill address
//   fill_len        number of bytes to fill (0..2**ADDR_WIDTH)
//   fill_value      fill byte
//   fill_busy       fill in progress (registered)
//   fill_done       one-cycle pulse on fill completion (registered)
//   vram_addr       registered write address
//   vram_data       registered write data
//   vram_we         registered write enable
// ---------------------------------------------------------------------------
module vram_write_scheduler #(
    parameter int ADDR_WIDTH = 12,
    parameter int VRAM_SIZE  = 2304
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vram_writable,
    input  logic                  cpu_valid,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_data,
    output logic                  cpu_ready,
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH:0]   fill_len,
    input  logic [7:0]            fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [7:0]            vram_data,
    output logic                  vram_we
);

    // Address arithmetic uses one extra bit, so VRAM_SIZE and a full-range
    // length can be represented without wrapping.
    localparam logic [ADDR_WIDTH:0] LP_SIZE = (ADDR_WIDTH+1)'(VRAM_SIZE);
    localparam logic [ADDR_WIDTH:0] LP_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] LP_LAST = LP_SIZE - LP_ONE;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_offset;
    logic [7:0]            r_value;

    logic                  r_vram_we;
    logic [ADDR_WIDTH-1:0] r_vram_addr;
    logic [7:0]            r_vram_data;
    logic                  r_fill_busy;
    logic                  r_fill_done;

    logic                  w_cpu_ready;
    logic                  w_cpu_accept;
    logic                  w_cpu_in_range;
    logic [ADDR_WIDTH:0]   w_fill_addr;
    logic                  w_fill_issue;
    logic                  w_fill_last;
    logic                  w_start_ok;

    // The CPU sees ready whenever the port can be written. Its accept
    // therefore depends only on the window and never on the fill state.
    assign w_cpu_ready    = vram_writable & ~rst;
    assign w_cpu_accept   = cpu_valid & w_cpu_ready;
    assign w_cpu_in_range = ({1'b0, cpu_addr} < LP_SIZE);

    // The fill takes a slot only when the window is open and the CPU has
    // not claimed the slot.
    assign w_fill_addr  = {1'b0, r_base} + r_offset;
    assign w_fill_issue = (r_state == ST_FILL) & vram_writable & ~w_cpu_accept;

    // The fill stops on whichever limit it reaches first: the requested
    // length or the top of VRAM. The remaining bytes are discarded, so the
    // fill never wraps.
    assign w_fill_last = ((r_offset + LP_ONE) == r_len) || (w_fill_addr == LP_LAST);

    // A start with nothing to do only produces the completion pulse.
    assign w_start_ok = (fill_len != '0) && ({1'b0, fill_base} < LP_SIZE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_offset    <= '0;
            r_value     <= '0;
            r_vram_we   <= 1'b0;
            r_vram_addr <= '0;
            r_vram_data <= '0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
        end else begin
            r_vram_we   <= 1'b0;
            r_fill_done <= 1'b0;

            // Write port stage: at most one source drives the port each cycle
            if (w_cpu_accept) begin
                r_vram_addr <= cpu_addr;
                r_vram_data <= cpu_data;
                // An out-of-range CPU write is still accepted, but it is dropped.
                r_vram_we   <= w_cpu_in_range;
            end else if (w_fill_issue) begin
                r_vram_addr <= w_fill_addr[ADDR_WIDTH-1:0];
                r_vram_data <= r_value;
                r_vram_we   <= 1'b1;
            end

            // Fill control stage
            case (r_state)
                ST_IDLE: begin
                    if (fill_start) begin
                        if (w_start_ok) begin
                            r_state     <= ST_FILL;
                            r_base      <= fill_base;
                            r_len       <= fill_len;
                            r_value     <= fill_value;
                            r_offset    <= '0;
                            r_fill_busy <= 1'b1;
                        end else begin
                            r_fill_done <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    // A fill_start that arrives while a fill is running is ignored.
                    if (w_fill_issue) begin
                        r_offset <= r_offset + LP_ONE;
                        if (w_fill_last) begin
                            r_state     <= ST_IDLE;
                            r_fill_busy <= 1'b0;
                            r_fill_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_fill_busy <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ready = w_cpu_ready;
    assign fill_busy = r_fill_busy;
    assign fill_done = r_fill_done;
    assign vram_addr = r_vram_addr;
    assign vram_data = r_vram_data;
    assign vram_we   = r_vram_we;

endmodule

// File: tb/tb_vram_write_scheduler.sv
module tb_vram_write_scheduler;

    logic        clk;
    logic        rst;
    logic        vram_writable;
    logic        cpu_valid;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ready;
    logic        fill_start;
    logic [11:0] fill_base;
    logic [12:0] fill_len;
    logic [7:0]  fill_value;
    logic        fill_busy;
    logic        fill_done;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic        vram_we;

    vram_write_scheduler #(
        .ADDR_WIDTH(12),
        .VRAM_SIZE (2304)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vram_writable(vram_writable),
        .cpu_valid    (cpu_valid),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_ready    (cpu_ready),
        .fill_start   (fill_start),
        .fill_base    (fill_base),
        .fill_len     (fill_len),
        .fill_value   (fill_value),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .vram_addr    (vram_addr),
        .vram_data    (vram_data),
        .vram_we      (vram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record describes one clock cycle. It holds the inputs for the
    // cycle, the expected cpu_ready during the cycle, and the expected
    // registered outputs just after the closing edge.
    typedef struct {
        string       nm;
        logic        r;
        logic        wr;
        logic        cv;
        logic [11:0] ca;
        logic [7:0]  cd;
        logic        fs;
        logic [11:0] fb;
        logic [12:0] fl;
        logic [7:0]  fv;
        logic        rdy;
        logic        we;
        logic [11:0] ad;
        logic [7:0]  da;
        logic        busy;
        logic        done;
        logic        chkad;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_err;

    task automatic add(input string nm, input logic r, input logic wr, input logic cv,
                       input logic [11:0] ca, input logic [7:0] cd, input logic fs,
                       input logic [11:0] fb, input logic [12:0] fl, input logic [7:0] fv,
                       input logic rdy, input logic we, input logic [11:0] ad,
                       input logic [7:0] da, input logic busy, input logic done,
                       input logic chkad);
        vec_t v;
        v.nm = nm; v.r = r; v.wr = wr; v.cv = cv; v.ca = ca; v.cd = cd;
        v.fs = fs; v.fb = fb; v.fl = fl; v.fv = fv; v.rdy = rdy; v.we = we;
        v.ad = ad; v.da = da; v.busy = busy; v.done = done; v.chkad = chkad;
        tbl.push_back(v);
    endtask

    // Idle cycle: no CPU request and no fill start.
    task automatic idl(input string nm, input logic wr, input logic we, input logic [11:0] ad,
                       input logic [7:0] da, input logic busy, input logic done);
        add(nm, 1'b0, wr, 1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 13'h0, 8'h0,
            wr, we, ad, da, busy, done, we);
    endtask

    // Fill-start pulse with the window open.
    task automatic fst(input string nm, input logic [11:0] fb, input logic [12:0] fl,
                       input logic [7:0] fv, input logic we, input logic [11:0] ad,
                       input logic [7:0] da, input logic busy, input logic done);
        add(nm, 1'b0, 1'b1, 1'b0, 12'h0, 8'h0, 1'b1, fb, fl, fv,
            1'b1, we, ad, da, busy, done, we);
    endtask

    // CPU request with the window open.
    task automatic cpu(input string nm, input logic [11:0] ca, input logic [7:0] cd,
                       input logic we, input logic [11:0] ad, input logic [7:0] da,
                       input logic busy, input logic done, input logic chkad);
        add(nm, 1'b0, 1'b1, 1'b1, ca, cd, 1'b0, 12'h0, 13'h0, 8'h0,
            1'b1, we, ad, da, busy, done, chkad);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; vram_writable = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_data = '0;
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        drive_idle();
        rst = 1'b1;

        // reset and idle
        add("rst", 1'b1, 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 13'h0, 8'h0,
            1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b1);
        idl("idle_wr", 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);
        idl("idle_nowr", 1'b0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);

        // basic four-byte fill
        fst("f4_start", 12'h400, 13'd4, 8'hAA, 1'b0, 12'h0, 8'h0, 1'b1, 1'b0);
        idl("f4_w0", 1'b1, 1'b1, 12'h400, 8'hAA, 1'b1, 1'b0);
        idl("f4_w1", 1'b1, 1'b1, 12'h401, 8'hAA, 1'b1, 1'b0);
        idl("f4_w2", 1'b1, 1'b1, 12'h402, 8'hAA, 1'b1, 1'b0);
        idl("f4_w3", 1'b1, 1'b1, 12'h403, 8'hAA, 1'b0, 1'b1);
        idl("f4_end", 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);

        // CPU write interleaved with the same fill
        fst("fc_start", 12'h400, 13'd4, 8'hAA, 1'b0, 12'h0, 8'h0, 1'b1, 1'b0);
        idl("fc_w0", 1'b1, 1'b1, 12'h400, 8'hAA, 1'b1, 1'b0);
        idl("fc_w1", 1'b1, 1'b1, 12'h401, 8'hAA, 1'b1, 1'b0);
        cpu("fc_cpu", 12'h010, 8'h5C, 1'b1, 12'h010, 8'h5C, 1'b1, 1'b0, 1'b1);
        idl("fc_w2", 1'b1, 1'b1, 12'h402, 8'hAA, 1'b1, 1'b0);
        idl("fc_w3", 1'b1, 1'b1, 12'h403, 8'hAA, 1'b0, 1'b1);
        idl("fc_end", 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);

        // fill clipped at the top of VRAM, then CPU writes at the boundary
        fst("top_start", 12'h8FE, 13'd10, 8'h33, 1'b0, 12'h0, 8'h0, 1'b1, 1'b0);
        idl("top_w0", 1'b1, 1'b1, 12'h8FE, 8'h33, 1'b1, 1'b0);
        idl("top_w1", 1'b1, 1'b1, 12'h8FF, 8'h33, 1'b0, 1'b1);
        idl("top_end", 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);
        cpu("cpu_oob", 12'h900, 8'h77, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        cpu("cpu_last", 12'h8FF, 8'h12, 1'b1, 12'h8FF, 8'h12, 1'b0, 1'b0, 1'b1);

        // single-byte fill at the last address
        fst("one_start", 12'h8FF, 13'd1, 8'hE7, 1'b0, 12'h0, 8'h0, 1'b1, 1'b0);
        idl("one_w0", 1'b1, 1'b1, 12'h8FF, 8'hE7, 1'b0, 1'b1);
        idl("one_end", 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);

        // window closes for three cycles in the middle of a fill
        fst("p_start", 12'h000, 13'd6, 8'h5A, 1'b0, 12'h0, 8'h0, 1'b1, 1'b0);
        idl("p_w0", 1'b1, 1'b1, 12'h000, 8'h5A, 1'b1, 1'b0);
        idl("p_w1", 1'b1, 1'b1, 12'h001, 8'h5A, 1'b1, 1'b0);
        idl("p_low0", 1'b0, 1'b0, 12'h0, 8'h0, 1'b1, 1'b0);
        add("p_low_cpu", 1'b0, 1'b0, 1'b1, 12'h123, 8'h99, 1'b0, 12'h0, 13'h0, 8'h0,
            1'b0, 1'b0, 12'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        idl("p_low2", 1'b0, 1'b0, 12'h0, 8'h0, 1'b1, 1'b0);
        idl("p_w2", 1'b1, 1'b1, 12'h002, 8'h5A, 1'b1, 1'b0);
        idl("p_w3", 1'b1, 1'b1, 12'h003, 8'h5A, 1'b1, 1'b0);
        idl("p_w4", 1'b1, 1'b1, 12'h004, 8'h5A, 1'b1, 1'b0);
        idl("p_w5", 1'b1, 1'b1, 12'h005, 8'h5A, 1'b0, 1'b1);
        idl("p_end", 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);

        // starts that produce no writes
        fst("len0", 12'h100, 13'd0, 8'h77, 1'b0, 12'h0, 8'h0, 1'b0, 1'b1);
        idl("len0_after", 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);
        fst("base_oob", 12'h900, 13'd5, 8'h77, 1'b0, 12'h0, 8'h0, 1'b0, 1'b1);
        idl("base_oob_after", 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);

        // a second fill_start during a fill is ignored
        fst("ign_start", 12'h200, 13'd3, 8'h11, 1'b0, 12'h0, 8'h0, 1'b1, 1'b0);
        fst("ign_again", 12'h300, 13'd8, 8'h22, 1'b1, 12'h200, 8'h11, 1'b1, 1'b0);
        idl("ign_w1", 1'b1, 1'b1, 12'h201, 8'h11, 1'b1, 1'b0);
        idl("ign_w2", 1'b1, 1'b1, 12'h202, 8'h11, 1'b0, 1'b1);
        idl("ign_end", 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r; vram_writable = tbl[i].wr; cpu_valid = tbl[i].cv;
            cpu_addr = tbl[i].ca; cpu_data = tbl[i].cd; fill_start = tbl[i].fs;
            fill_base = tbl[i].fb; fill_len = tbl[i].fl; fill_value = tbl[i].fv;
            #1;
            n_vec++;
            chk(tbl[i].nm, "cpu_ready", 32'(cpu_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk(tbl[i].nm, "vram_we", 32'(vram_we), 32'(tbl[i].we));
            if (tbl[i].chkad) begin
                chk(tbl[i].nm, "vram_addr", 32'(vram_addr), 32'(tbl[i].ad));
                chk(tbl[i].nm, "vram_data", 32'(vram_data), 32'(tbl[i].da));
            end
            chk(tbl[i].nm, "fill_busy", 32'(fill_busy), 32'(tbl[i].busy));
            chk(tbl[i].nm, "fill_done", 32'(fill_done), 32'(tbl[i].done));
        end

        // Reset during a fill. In that reset cycle rst also overrides a
        // fill_start and a CPU request.
        @(negedge clk);
        drive_idle();
        fill_start = 1'b1; fill_base = 12'h050; fill_len = 13'd8; fill_value = 8'h44;
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; fill_start = 1'b1; fill_base = 12'h600; fill_len = 13'd4;
        cpu_valid = 1'b1; cpu_addr = 12'h010; cpu_data = 8'h66;
        #1;
        n_vec++;
        chk("rst_mid", "cpu_ready", 32'(cpu_ready), 32'd0);
        @(posedge clk);
        #1;
        n_vec++;
        chk("rst_mid", "vram_we", 32'(vram_we), 32'd0);
        chk("rst_mid", "fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_mid", "fill_done", 32'(fill_done), 32'd0);
        chk("rst_mid", "vram_addr", 32'(vram_addr), 32'h0);
        chk("rst_mid", "vram_data", 32'(vram_data), 32'h0);
        @(negedge clk);
        drive_idle();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            chk("rst_quiet", "vram_we", 32'(vram_we), 32'd0);
            chk("rst_quiet", "fill_busy", 32'(fill_busy), 32'd0);
            chk("rst_quiet", "fill_done", 32'(fill_done), 32'd0);
        end

        // A full-length fill near the top of VRAM writes only up to 0x8FF.
        begin
            int  nw;
            bit  got_done;
            nw = 0;
            got_done = 1'b0;
            @(negedge clk);
            fill_start = 1'b1; fill_base = 12'h8F0; fill_len = 13'h1000; fill_value = 8'hC3;
            @(posedge clk);
            #1;
            n_vec++;
            chk("long_start", "fill_busy", 32'(fill_busy), 32'd1);
            @(negedge clk);
            drive_idle();
            for (int c = 0; c < 40 && !got_done; c++) begin
                @(posedge clk);
                #1;
                if (vram_we) begin
                    n_vec++;
                    chk("long_wr", "vram_addr", 32'(vram_addr), 32'h8F0 + 32'(nw));
                    chk("long_wr", "vram_data", 32'(vram_data), 32'hC3);
                    nw++;
                end
                if (fill_done) got_done = 1'b1;
            end
            n_vec++;
            chk("long_done", "fill_done_seen", 32'(got_done), 32'd1);
            chk("long_done", "write_count", 32'(nw), 32'd16);
            chk("long_done", "fill_busy", 32'(fill_busy), 32'd0);
            @(posedge clk);
            #1;
            n_vec++;
            chk("long_after", "fill_done", 32'(fill_done), 32'd0);
            chk("long_after", "vram_we", 32'(vram_we), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
